// File: rtl/bp_profiler_sample_ctrl.sv
// Profiler sampling scheduler: gates bank counting, times samples, streams counters to host.
// Optional BP_PROF_SAMPLE_HEADER_EN prefixes each stream with an 8'hA5 header word.
module bp_profiler_sample_ctrl #(
    parameter int width_p = 32,
    parameter int num_ctrs_p = 75,
    localparam int lg_num_ctrs_lp = (num_ctrs_p > 1) ? $clog2(num_ctrs_p) : 1
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      trigger_i,
    input  logic                      auto_clear_i,
    input  logic [width_p-1:0]        interval_i,
    input  logic [width_p-1:0]        ctr_data_i,
    output logic [lg_num_ctrs_lp-1:0] ctr_sel_o,
    output logic                      en_o,
    output logic                      clear_o,
    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    input  logic                      ready_i,
    output logic                      busy_o,
    output logic                      overrun_o,
    output logic [width_p-1:0]        sample_cnt_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] CLEAR  = 2'd3;

    localparam logic [width_p-1:0] one_lp = width_p'(1);
    localparam logic [lg_num_ctrs_lp-1:0] last_idx_lp =
        lg_num_ctrs_lp'(num_ctrs_p - 1);

    logic [1:0]                state;
    logic [width_p-1:0]        timer;
    logic [lg_num_ctrs_lp-1:0] idx;
    logic [width_p-1:0]        sample_cnt;
    logic                      overrun;
    logic                      stop_pend;
    logic                      from_idle;
    logic                      hdr;

    logic expire;
    logic accept;
    logic end_to_idle;
    logic [width_p-1:0] hdr_word;

    assign expire = (interval_i != '0) && (timer == interval_i - one_lp);
    assign accept = v_o & ready_i;
    // A sample started from IDLE, or with a stop seen, ends back in IDLE.
    assign end_to_idle = stop_pend | stop_i | from_idle;
    assign hdr_word = {8'hA5, sample_cnt[width_p-9:0]};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            sample_cnt <= '0;
            overrun    <= 1'b0;
            stop_pend  <= 1'b0;
            from_idle  <= 1'b0;
            hdr        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) overrun <= 1'b0;
                    if (trigger_i) begin
                        state     <= STREAM;
                        from_idle <= ~start_i;
                        timer     <= '0;
                        idx       <= '0;
                        stop_pend <= 1'b0;
`ifdef BP_PROF_SAMPLE_HEADER_EN
                        hdr       <= 1'b1;
`endif
                    end else if (start_i) begin
                        state <= ARMED;
                        timer <= '0;
                    end
                end
                ARMED: begin
                    if (stop_i) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (trigger_i || expire) begin
                        state     <= STREAM;
                        timer     <= '0;
                        idx       <= '0;
                        from_idle <= 1'b0;
                        stop_pend <= 1'b0;
`ifdef BP_PROF_SAMPLE_HEADER_EN
                        hdr       <= 1'b1;
`endif
                    end else begin
                        timer <= timer + one_lp;
                    end
                end
                STREAM: begin
                    timer <= '0;
                    if (trigger_i || expire) overrun <= 1'b1;
                    if (stop_i) stop_pend <= 1'b1;
                    if (accept) begin
                        if (hdr) begin
                            hdr <= 1'b0;
                        end else if (idx == last_idx_lp) begin
                            idx        <= '0;
                            sample_cnt <= sample_cnt + one_lp;
                            if (auto_clear_i) begin
                                state <= CLEAR;
                            end else begin
                                state     <= end_to_idle ? IDLE : ARMED;
                                stop_pend <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    timer     <= '0;
                    if (trigger_i || expire) overrun <= 1'b1;
                    state     <= end_to_idle ? IDLE : ARMED;
                    stop_pend <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        en_o    = (state == ARMED);
        clear_o = (state == CLEAR);
        v_o     = (state == STREAM);
        busy_o  = (state == STREAM) || (state == CLEAR);
        data_o  = '0;
        if (v_o) data_o = hdr ? hdr_word : ctr_data_i;
    end

    assign ctr_sel_o    = idx;
    assign overrun_o    = overrun;
    assign sample_cnt_o = sample_cnt;

endmodule

// File: tb/tb_bp_profiler_sample_ctrl.sv
// Scoreboard bench for bp_profiler_sample_ctrl: stimulus pushes expected stream
// words, a negedge monitor pops and compares every accepted word.
module tb_bp_profiler_sample_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic        trigger_i = 1'b0;
    logic        auto_clear_i = 1'b0;
    logic [31:0] interval_i = '0;
    logic [31:0] ctr_data;
    logic [6:0]  ctr_sel;
    logic        en_o;
    logic        clear_o;
    logic        v_o;
    logic [31:0] data_o;
    logic        ready_i = 1'b1;
    logic        busy_o;
    logic        overrun_o;
    logic [31:0] sample_cnt_o;

    typedef struct {
        logic [31:0] d;
        logic [6:0]  s;
    } word_t;

    word_t sb[$];
    int n_tests = 0;
    int n_fail = 0;
    int cnt_exp = 0;

`ifdef BP_PROF_SAMPLE_HEADER_EN
    localparam int NW = 76;
`else
    localparam int NW = 75;
`endif

    always #5 clk = ~clk;

    // Counter bank model: counter i holds 5A000000 + i*00010101.
    assign ctr_data = 32'h5A00_0000 + 32'(ctr_sel) * 32'h0001_0101;

    bp_profiler_sample_ctrl dut (
        .clk_i        (clk),
        .reset_n_i    (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .trigger_i    (trigger_i),
        .auto_clear_i (auto_clear_i),
        .interval_i   (interval_i),
        .ctr_data_i   (ctr_data),
        .ctr_sel_o    (ctr_sel),
        .en_o         (en_o),
        .clear_o      (clear_o),
        .v_o          (v_o),
        .data_o       (data_o),
        .ready_i      (ready_i),
        .busy_o       (busy_o),
        .overrun_o    (overrun_o),
        .sample_cnt_o (sample_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample();
        word_t w;
`ifdef BP_PROF_SAMPLE_HEADER_EN
        logic [31:0] c;
        c = 32'(cnt_exp);
        w.d = {8'hA5, c[23:0]};
        w.s = 7'd0;
        sb.push_back(w);
`endif
        for (int i = 0; i < 75; i++) begin
            w.d = 32'h5A00_0000 + 32'(i) * 32'h0001_0101;
            w.s = 7'(i);
            sb.push_back(w);
        end
        cnt_exp++;
    endtask

    always @(negedge clk) begin
        if (rst_n && v_o && ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_word", data_o, 32'hxxxx_xxxx);
            end else begin
                word_t e;
                e = sb.pop_front();
                chk("word_data", data_o, e.d);
                chk("word_sel", {25'd0, ctr_sel}, {25'd0, e.s});
            end
        end
    end

    task automatic wait_armed(input int exp_cycles);
        int cnt;
        cnt = 0;
        while (en_o && !v_o && cnt < 1000) begin
            cnt++;
            tick();
        end
        chk("armed_cycles", 32'(cnt), 32'(exp_cycles));
    endtask

    initial begin
        int w;
        int k;
        int found;
        logic hold;
        logic [31:0] pd;
        logic [6:0] ps;

        #1;
        chk("rst_en", {31'd0, en_o}, 0);
        chk("rst_v", {31'd0, v_o}, 0);
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_overrun", {31'd0, overrun_o}, 0);
        chk("rst_cnt", sample_cnt_o, 0);
        chk("rst_sel", {25'd0, ctr_sel}, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // A: periodic sample, interval 100, no clear
        interval_i = 32'd100;
        push_sample();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_armed(100);
        w = 0;
        while (v_o && w < 300) begin
            chk("a_en_frozen", {31'd0, en_o}, 0);
            if (ready_i) w++;
            tick();
        end
        chk("a_words", 32'(w), 32'(NW));
        chk("a_en_after", {31'd0, en_o}, 1);
        chk("a_cnt", sample_cnt_o, 1);
        chk("a_sb_empty", 32'(sb.size()), 0);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        chk("a_stop_idle", {31'd0, en_o}, 0);

        // B: auto clear with ready 1-of-3
        auto_clear_i = 1'b1;
        push_sample();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_armed(100);
        w = 0;
        k = 0;
        hold = 1'b0;
        pd = '0;
        ps = '0;
        while (v_o && w < 300) begin
            ready_i = (k % 3 == 2);
            if (hold) begin
                chk("b_hold_data", data_o, pd);
                chk("b_hold_sel", {25'd0, ctr_sel}, {25'd0, ps});
            end
            hold = !ready_i;
            pd = data_o;
            ps = ctr_sel;
            if (ready_i) w++;
            k++;
            tick();
        end
        ready_i = 1'b1;
        chk("b_words", 32'(w), 32'(NW));
        chk("b_clear", {31'd0, clear_o}, 1);
        chk("b_clear_busy", {31'd0, busy_o}, 1);
        chk("b_clear_en", {31'd0, en_o}, 0);
        tick();
        chk("b_clear_once", {31'd0, clear_o}, 0);
        chk("b_armed", {31'd0, en_o}, 1);
        chk("b_cnt", sample_cnt_o, 2);
        chk("b_sb_empty", 32'(sb.size()), 0);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        auto_clear_i = 1'b0;

        // C: trigger-only from IDLE
        interval_i = 32'd0;
        push_sample();
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        w = 0;
        while (v_o && w < 300) begin
            chk("c_en_frozen", {31'd0, en_o}, 0);
            w++;
            tick();
        end
        chk("c_words", 32'(w), 32'(NW));
        chk("c_idle_busy", {31'd0, busy_o}, 0);
        chk("c_cnt", sample_cnt_o, 3);
        chk("c_overrun", {31'd0, overrun_o}, 0);
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (en_o || v_o) k++;
            tick();
        end
        chk("c_stays_idle", 32'(k), 0);
        chk("c_sb_empty", 32'(sb.size()), 0);

        // D: overrun at word 10, stop at word 20
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        push_sample();
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        w = 0;
        while (v_o && w < 300) begin
            trigger_i = (w == 10);
            stop_i = (w == 20);
            w++;
            tick();
        end
        trigger_i = 1'b0;
        stop_i = 1'b0;
        chk("d_words", 32'(w), 32'(NW));
        chk("d_overrun", {31'd0, overrun_o}, 1);
        chk("d_idle_en", {31'd0, en_o}, 0);
        chk("d_idle_busy", {31'd0, busy_o}, 0);
        chk("d_cnt", sample_cnt_o, 4);
        k = 0;
        for (int i = 0; i < 20; i++) begin
            if (v_o) k++;
            tick();
        end
        chk("d_no_second", 32'(k), 0);
        chk("d_overrun_sticky", {31'd0, overrun_o}, 1);
        chk("d_sb_empty", 32'(sb.size()), 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("d_overrun_clr", {31'd0, overrun_o}, 0);
        chk("d_start_en", {31'd0, en_o}, 1);

        // E: reset mid-stream at counter 40
        push_sample();
        trigger_i = 1'b1;
        tick();
        trigger_i = 1'b0;
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (v_o && ctr_sel == 7'd40) found = 1;
            else tick();
        end
        chk("e_reach_40", 32'(found), 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        cnt_exp = 0;
        chk("e_rst_v", {31'd0, v_o}, 0);
        chk("e_rst_sel", {25'd0, ctr_sel}, 0);
        chk("e_rst_data", data_o, 0);
        chk("e_rst_cnt", sample_cnt_o, 0);
        tick();
        chk("e_rst_en", {31'd0, en_o}, 0);
        chk("e_rst_busy", {31'd0, busy_o}, 0);
        chk("e_rst_clear", {31'd0, clear_o}, 0);
        rst_n = 1'b1;
        tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("e_start_en", {31'd0, en_o}, 1);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            if (v_o) k++;
            tick();
        end
        chk("e_no_stale_v", 32'(k), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
